// File: rtl/user_pkg.sv
// Shared user-domain types and constants: OBI structs and SPI NOR flash command set.
package user_pkg;

  localparam int unsigned ObiIdWidth     = 4;
  localparam logic [31:0] FlashAddrRange = 32'h0100_0000;
  localparam logic [7:0]  FlashCmdRead     = 8'h03;
  localparam logic [7:0]  FlashCmdFastRead = 8'h0B;
  localparam int unsigned FlashAddrWidth = 24;
  localparam int unsigned FlashDummyBits = 8;
  localparam int unsigned FlashDataBits  = 32;
  localparam int unsigned FlashMaxFrame  = 8 + FlashAddrWidth + FlashDummyBits + FlashDataBits;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [ObiIdWidth-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [ObiIdWidth-1:0] rid;
    logic                  err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  typedef enum logic [1:0] {FlashIdle, FlashShift, FlashResp} flash_state_e;

  // Serial stream arrives byte0 first; the bus word is little-endian.
  function automatic logic [31:0] flash_pack_le(input logic [31:0] stream);
    return {stream[7:0], stream[15:8], stream[23:16], stream[31:24]};
  endfunction

endpackage

// File: rtl/user_flash_spi_shifter.sv
// Mode-0 single-I/O SPI frame engine: divider, bit counter, SCK/MOSI drive, MISO capture.
module user_flash_spi_shifter
  import user_pkg::*;
#(
  parameter int unsigned ClkDiv = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [6:0]               frame_len_i,
  input  logic [FlashMaxFrame-1:0] tx_frame_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              rx_word_o,
  output logic                     spi_sck_o,
  output logic                     spi_csb_o,
  output logic                     spi_mosi_o,
  input  logic                     spi_miso_i
);

  localparam logic [7:0] DivLast = 8'(ClkDiv - 1);

  logic                     active_q;
  logic                     sck_q;
  logic [7:0]               div_q;
  logic [6:0]               bit_q;
  logic [6:0]               len_q;
  logic [FlashMaxFrame-1:0] tx_q;
  logic [31:0]              rx_q;

  logic div_wrap, rise, fall, last_bit, in_rx;

  assign div_wrap = (div_q == DivLast);
  assign rise     = active_q & div_wrap & ~sck_q;
  assign fall     = active_q & div_wrap & sck_q;
  assign last_bit = (bit_q == len_q - 7'd1);
  assign in_rx    = (bit_q >= len_q - 7'd32);

  assign done_o     = fall & last_bit;
  assign busy_o     = active_q;
  assign rx_word_o  = rx_q;
  assign spi_sck_o  = sck_q;
  assign spi_csb_o  = ~active_q;
  assign spi_mosi_o = active_q & tx_q[FlashMaxFrame-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (start_i && !active_q) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      len_q    <= frame_len_i;
      tx_q     <= tx_frame_i;
    end else if (active_q) begin
      div_q <= div_wrap ? 8'd0 : div_q + 8'd1;
      if (div_wrap) sck_q <= ~sck_q;
      if (rise && in_rx) rx_q <= {rx_q[30:0], spi_miso_i};
      // Advance on the falling edge so MOSI only changes while SCK is low.
      if (fall) begin
        if (last_bit) begin
          active_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 7'd1;
          tx_q  <= {tx_q[FlashMaxFrame-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/user_flash_obi_spi.sv
// OBI subordinate turning reads into single-word SPI NOR reads; writes answer with err.
// Define USER_FLASH_FAST_READ_EN to use Fast Read (0x0B) with 8 dummy bits.
module user_flash_obi_spi
  import user_pkg::*;
#(
  parameter int unsigned ClkDiv = 2,
  parameter type obi_req_t = user_pkg::obi_req_t,
  parameter type obi_rsp_t = user_pkg::obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     spi_sck_o,
  output logic     spi_csb_o,
  output logic     spi_mosi_o,
  input  logic     spi_miso_i
);

  flash_state_e            state_q;
  logic                    rvalid_q;
  logic                    err_q;
  logic [31:0]             rdata_q;
  logic [ObiIdWidth-1:0]   rid_q;

  logic                      gnt, start, busy, done;
  logic [31:0]               rx_word;
  logic [FlashAddrWidth-1:0] flash_addr;
  logic [FlashMaxFrame-1:0]  frame;
  logic [6:0]                frame_len;
  logic                      unused_in;

  assign gnt        = obi_req_i.req & (state_q == FlashIdle);
  assign start      = gnt & ~obi_req_i.a.we;
  assign flash_addr = {obi_req_i.a.addr[FlashAddrWidth-1:2], 2'b00};

`ifdef USER_FLASH_FAST_READ_EN
  assign frame     = {FlashCmdFastRead, flash_addr, FlashDummyBits'(0), 32'h0};
  assign frame_len = 7'd72;
`else
  // 64-bit frame left-aligned in the 72-bit shift register.
  assign frame     = {FlashCmdRead, flash_addr, 32'h0, 8'h0};
  assign frame_len = 7'd64;
`endif

  assign unused_in = ^{obi_req_i.a.addr[31:FlashAddrWidth], obi_req_i.a.be,
                       obi_req_i.a.wdata, busy};

  user_flash_spi_shifter #(.ClkDiv(ClkDiv)) i_shifter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .frame_len_i (frame_len),
    .tx_frame_i  (frame),
    .busy_o      (busy),
    .done_o      (done),
    .rx_word_o   (rx_word),
    .spi_sck_o   (spi_sck_o),
    .spi_csb_o   (spi_csb_o),
    .spi_mosi_o  (spi_mosi_o),
    .spi_miso_i  (spi_miso_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FlashIdle;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      case (state_q)
        FlashIdle: begin
          rvalid_q <= 1'b0;
          if (gnt) begin
            rid_q <= obi_req_i.a.aid;
            if (obi_req_i.a.we) begin
              err_q    <= 1'b1;
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
              state_q  <= FlashResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= FlashShift;
            end
          end
        end
        FlashShift: begin
          if (done) begin
            rdata_q  <= flash_pack_le(rx_word);
            rvalid_q <= 1'b1;
            state_q  <= FlashResp;
          end
        end
        FlashResp: begin
          rvalid_q <= 1'b0;
          state_q  <= FlashIdle;
        end
        default: begin
          rvalid_q <= 1'b0;
          state_q  <= FlashIdle;
        end
      endcase
    end
  end

  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = gnt;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

endmodule

// File: tb/tb_user_flash_obi_spi.sv
// Directed bench for user_flash_obi_spi with a behavioural SPI NOR flash model.
module tb_user_flash_obi_spi;
  import user_pkg::*;

`ifdef USER_FLASH_FAST_READ_EN
  localparam int ClkDiv    = 1;
  localparam int HdrBits   = 40;
  localparam int FrameBits = 72;
  localparam logic [39:0] HdrExp = 40'h0B_0001_0400;
`else
  localparam int ClkDiv    = 2;
  localparam int HdrBits   = 32;
  localparam int FrameBits = 64;
  localparam logic [39:0] HdrExp = 40'h00_0300_0104;
`endif
  localparam int Lat = 1 + FrameBits * 2 * ClkDiv;

  logic     clk, rst_n;
  obi_req_t req;
  obi_rsp_t rsp;
  logic     sck, csb, mosi, miso;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int csb_low_cnt = 0;

  user_flash_obi_spi #(.ClkDiv(ClkDiv)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .obi_req_i  (req),
    .obi_rsp_o  (rsp),
    .spi_sck_o  (sck),
    .spi_csb_o  (csb),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rsp.rvalid) rv_cnt++;
    if (!csb) csb_low_cnt++;
  end

  // Flash model: shifts in command/address on SCK rise, drives data on SCK fall.
  int          fl_cnt = 0;
  logic [39:0] fl_sr  = '0;
  logic [39:0] fl_hdr = '0;
  logic [23:0] fl_addr;
`ifdef USER_FLASH_FAST_READ_EN
  assign fl_addr = fl_hdr[31:8];
`else
  assign fl_addr = fl_hdr[23:0];
`endif

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h11;
      24'h000105: return 8'h22;
      24'h000106: return 8'h33;
      24'h000107: return 8'h44;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge sck or negedge csb) begin
    if (!sck) begin
      fl_cnt = 0;
      fl_sr  = '0;
    end else begin
      fl_sr = {fl_sr[38:0], mosi};
      fl_cnt++;
      if (fl_cnt == HdrBits) fl_hdr = fl_sr;
    end
  end

  initial miso = 1'b0;
  always @(negedge sck) begin
    int idx;
    logic [7:0] b;
    if (fl_cnt >= HdrBits && fl_cnt < HdrBits + 32) begin
      idx  = fl_cnt - HdrBits;
      b    = mem_byte(fl_addr + 24'(idx / 8));
      miso = b[3'(7 - idx % 8)];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic grant(input logic [31:0] addr, input logic we, input logic [3:0] aid,
                       input string tag, output int t0);
    @(negedge clk);
    req.req     = 1'b1;
    req.a.addr  = addr;
    req.a.we    = we;
    req.a.aid   = aid;
    req.a.be    = 4'hF;
    req.a.wdata = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_gnt"}, 64'(rsp.gnt), 64'd1);
    t0 = cyc;
  endtask

  task automatic wait_rv(input int budget, input logic hold, output int at_cyc, output int gnt_seen);
    at_cyc   = -1;
    gnt_seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!hold) req.req = 1'b0;
      #1;
      if (rsp.rvalid) begin
        at_cyc = cyc;
        break;
      end
      if (rsp.gnt) gnt_seen++;
    end
    if (at_cyc < 0) chk("rvalid_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_read(input string tag, input int t0, input int tr,
                            input logic [31:0] exp_data, input logic [3:0] exp_id);
    chk({tag, "_lat"},   64'(tr - t0), 64'(Lat));
    chk({tag, "_rdata"}, 64'(rsp.r.rdata), 64'(exp_data));
    chk({tag, "_err"},   64'(rsp.r.err), 64'd0);
    chk({tag, "_rid"},   64'(rsp.r.rid), 64'(exp_id));
    chk({tag, "_hdr"},   64'(fl_hdr), 64'(HdrExp));
  endtask

  initial begin
    int t0, tr, g, rv0, cl0;
    req   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt",    64'(rsp.gnt), 64'd0);
    chk("rst_rvalid", 64'(rsp.rvalid), 64'd0);
    chk("rst_rdata",  64'(rsp.r.rdata), 64'd0);
    chk("rst_rid",    64'(rsp.r.rid), 64'd0);
    chk("rst_err",    64'(rsp.r.err), 64'd0);
    chk("rst_sck",    64'(sck), 64'd0);
    chk("rst_csb",    64'(csb), 64'd1);
    chk("rst_mosi",   64'(mosi), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Aligned read
    grant(32'h2000_0104, 1'b0, 4'd5, "rd0", t0);
    wait_rv(Lat + 20, 1'b0, tr, g);
    check_read("rd0", t0, tr, 32'h4433_2211, 4'd5);
    chk("rd0_csb_at_rvalid", 64'(csb), 64'd1);
    chk("rd0_sck_at_rvalid", 64'(sck), 64'd0);

    // Unaligned read maps to the same word
    grant(32'h2000_0107, 1'b0, 4'd6, "rd1", t0);
    wait_rv(Lat + 20, 1'b0, tr, g);
    check_read("rd1", t0, tr, 32'h4433_2211, 4'd6);

    // Write is rejected without SPI activity
    cl0 = csb_low_cnt;
    grant(32'h2000_0000, 1'b1, 4'd3, "wr", t0);
    chk("wr_csb_gnt", 64'(csb), 64'd1);
    wait_rv(5, 1'b0, tr, g);
    chk("wr_lat",   64'(tr - t0), 64'd1);
    chk("wr_err",   64'(rsp.r.err), 64'd1);
    chk("wr_rdata", 64'(rsp.r.rdata), 64'd0);
    chk("wr_rid",   64'(rsp.r.rid), 64'd3);
    repeat (3) @(negedge clk);
    chk("wr_csb_quiet", 64'(csb_low_cnt - cl0), 64'd0);

    // Back-to-back reads with req held
    grant(32'h2000_0104, 1'b0, 4'd1, "b2b0", t0);
    wait_rv(Lat + 20, 1'b1, tr, g);
    check_read("b2b0", t0, tr, 32'h4433_2211, 4'd1);
    chk("b2b0_busy_gnt", 64'(g), 64'd0);
    chk("b2b0_gnt_resp", 64'(rsp.gnt), 64'd0);
    chk("b2b0_csb_gap1", 64'(csb), 64'd1);
    req.a.addr = 32'h2000_0200;
    req.a.aid  = 4'd2;
    @(negedge clk);
    #1;
    chk("b2b1_gnt", 64'(rsp.gnt), 64'd1);
    chk("b2b1_gnt_cyc", 64'(cyc - tr), 64'd1);
    chk("b2b_csb_gap2", 64'(csb), 64'd1);
    t0 = cyc;
    wait_rv(Lat + 20, 1'b0, tr, g);
    chk("b2b1_lat",   64'(tr - t0), 64'(Lat));
    chk("b2b1_rdata", 64'(rsp.r.rdata), 64'hA6A7_A4A5);
    chk("b2b1_rid",   64'(rsp.r.rid), 64'd2);

    // Reset mid-frame
    grant(32'h2000_0104, 1'b0, 4'd4, "rst_mid", t0);
    @(negedge clk);
    req.req = 1'b0;
    for (int i = 0; i < Lat && fl_cnt < 20; i++) @(negedge clk);
    chk("rst_mid_reached_bit20", 64'(fl_cnt >= 20), 64'd1);
    rv0 = rv_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_csb", 64'(csb), 64'd1);
    chk("rst_mid_sck", 64'(sck), 64'd0);
    chk("rst_mid_rvalid", 64'(rsp.rvalid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (Lat + 10) @(negedge clk);
    chk("rst_mid_no_rvalid", 64'(rv_cnt - rv0), 64'd0);
    grant(32'h2000_0107, 1'b0, 4'd9, "rd_post", t0);
    wait_rv(Lat + 20, 1'b0, tr, g);
    check_read("rd_post", t0, tr, 32'h4433_2211, 4'd9);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
